// File: rtl/sys_time_base.sv
// sys_time_base: day / ms-of-day / us-of-ms time base with validated load, snapshot handshake and tick pulses.
// Optional alarm comparator enabled by defining SYS_TIME_BASE_ALARM_EN.
module sys_time_base #(
    parameter int CLK_TICKS_PER_US = 60,
    parameter int US_PER_MS = 1000,
    parameter int MS_PER_DAY = 86400000,
    parameter int DAY_W = 16,
    localparam int US_W = $clog2(US_PER_MS),
    localparam int MS_W = $clog2(MS_PER_DAY)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [DAY_W-1:0] load_day,
    input  logic [MS_W-1:0]  load_ms,
    input  logic [US_W-1:0]  load_us,
    output logic             load_err,
    output logic [DAY_W-1:0] day,
    output logic [MS_W-1:0]  ms_of_day,
    output logic [US_W-1:0]  us_of_ms,
    output logic             us_tick,
    output logic             ms_tick,
    output logic             day_tick,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             snap_vld,
    output logic [DAY_W-1:0] snap_day,
    output logic [MS_W-1:0]  snap_ms,
    output logic [US_W-1:0]  snap_us,
    input  logic             clr_ovf,
`ifdef SYS_TIME_BASE_ALARM_EN
    input  logic             alarm_arm,
    input  logic [DAY_W-1:0] alarm_day,
    input  logic [MS_W-1:0]  alarm_ms,
    input  logic             alarm_clr,
    output logic             alarm_pend,
    output logic             day_ovf
`else
    output logic             day_ovf
`endif
);
    localparam int PSC_W = $clog2(CLK_TICKS_PER_US);
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(CLK_TICKS_PER_US - 1);
    localparam logic [US_W-1:0] US_MAX = US_W'(US_PER_MS - 1);
    localparam logic [MS_W-1:0] MS_MAX = MS_W'(MS_PER_DAY - 1);

    logic [PSC_W-1:0] psc;
    logic             term, us_wrap, ms_wrap, day_wrap, load_ok;
    logic [MS_W-1:0]  ms_nxt;
    logic [DAY_W-1:0] day_nxt;

    always_comb begin
        term     = psc == PSC_MAX;
        us_wrap  = term && us_of_ms == US_MAX;
        ms_wrap  = us_wrap && ms_of_day == MS_MAX;
        day_wrap = ms_wrap && &day;
        load_ok  = load && load_us <= US_MAX && load_ms <= MS_MAX;
        ms_nxt   = us_wrap ? (ms_wrap ? '0 : ms_of_day + 1'b1) : ms_of_day;
        day_nxt  = ms_wrap ? day + 1'b1 : day;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            psc       <= '0;
            us_of_ms  <= '0;
            ms_of_day <= '0;
            day       <= '0;
            us_tick   <= 1'b0;
            ms_tick   <= 1'b0;
            day_tick  <= 1'b0;
            load_err  <= 1'b0;
            day_ovf   <= 1'b0;
            snap_vld  <= 1'b0;
            snap_day  <= '0;
            snap_ms   <= '0;
            snap_us   <= '0;
        end else begin
            load_err <= load && !load_ok;
            day_ovf  <= (day_wrap && !load_ok) || (day_ovf && !clr_ovf);
            snap_vld <= snap_req || (snap_vld && !snap_ack);
            if (snap_req) begin
                snap_day <= day;
                snap_ms  <= ms_of_day;
                snap_us  <= us_of_ms;
            end
            // A valid load replaces the whole cascade, prescaler included
            if (load_ok) begin
                psc       <= '0;
                us_of_ms  <= load_us;
                ms_of_day <= load_ms;
                day       <= load_day;
                us_tick   <= 1'b0;
                ms_tick   <= 1'b0;
                day_tick  <= 1'b0;
            end else begin
                psc       <= term ? '0 : psc + 1'b1;
                us_of_ms  <= term ? (us_wrap ? '0 : us_of_ms + 1'b1) : us_of_ms;
                ms_of_day <= ms_nxt;
                day       <= day_nxt;
                us_tick   <= term;
                ms_tick   <= us_wrap;
                day_tick  <= ms_wrap;
            end
        end
    end

`ifdef SYS_TIME_BASE_ALARM_EN
    logic             armed, fire;
    logic [DAY_W-1:0] tgt_day;
    logic [MS_W-1:0]  tgt_ms;

    // Only a counted ms advance can fire, never a load
    assign fire = armed && !load_ok && us_wrap && ms_nxt == tgt_ms && day_nxt == tgt_day;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            armed      <= 1'b0;
            tgt_day    <= '0;
            tgt_ms     <= '0;
            alarm_pend <= 1'b0;
        end else begin
            armed      <= alarm_arm || (armed && !fire);
            alarm_pend <= fire || (alarm_pend && !alarm_clr);
            if (alarm_arm) begin
                tgt_day <= alarm_day;
                tgt_ms  <= alarm_ms;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sys_time_base.sv
// tb_sys_time_base: randomized and directed checks of sys_time_base against a linear-time reference model.
module tb_sys_time_base;
    localparam int CT = 4, UP = 10, MP = 20, DW = 4, UW = 4, MW = 5;
    localparam int DAYUS = UP * MP;
    localparam int FULL = DAYUS * (1 << DW);

    logic clk = 1'b0, n_rst = 1'b0, load = 1'b0;
    logic [DW-1:0] load_day = '0;
    logic [MW-1:0] load_ms = '0;
    logic [UW-1:0] load_us = '0;
    logic snap_req = 1'b0, snap_ack = 1'b0, clr_ovf = 1'b0;
    logic load_err, us_tick, ms_tick, day_tick, snap_vld, day_ovf;
    logic [DW-1:0] day, snap_day;
    logic [MW-1:0] ms_of_day, snap_ms;
    logic [UW-1:0] us_of_ms, snap_us;
`ifdef SYS_TIME_BASE_ALARM_EN
    logic alarm_arm = 1'b0, alarm_clr = 1'b0, alarm_pend;
    logic [DW-1:0] alarm_day = '0;
    logic [MW-1:0] alarm_ms = '0;
    bit m_armed, m_pend;
    int m_ad, m_am;
`endif

    sys_time_base #(.CLK_TICKS_PER_US(CT), .US_PER_MS(UP), .MS_PER_DAY(MP), .DAY_W(DW)) dut (
        .clk(clk), .n_rst(n_rst), .load(load), .load_day(load_day), .load_ms(load_ms),
        .load_us(load_us), .load_err(load_err), .day(day), .ms_of_day(ms_of_day),
        .us_of_ms(us_of_ms), .us_tick(us_tick), .ms_tick(ms_tick), .day_tick(day_tick),
        .snap_req(snap_req), .snap_ack(snap_ack), .snap_vld(snap_vld), .snap_day(snap_day),
        .snap_ms(snap_ms), .snap_us(snap_us), .clr_ovf(clr_ovf),
`ifdef SYS_TIME_BASE_ALARM_EN
        .alarm_arm(alarm_arm), .alarm_day(alarm_day), .alarm_ms(alarm_ms),
        .alarm_clr(alarm_clr), .alarm_pend(alarm_pend),
`endif
        .day_ovf(day_ovf));

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    // Model time is a single count of microseconds since day 0, modulo the day-counter span
    int m_t, m_psc, m_sd, m_sm, m_su;
    bit m_ut, m_mt, m_dt, m_err, m_ovf, m_sv;

    logic [31:0] dut_vec;
    assign dut_vec = {day, ms_of_day, us_of_ms, us_tick, ms_tick, day_tick, load_err, day_ovf,
                      snap_vld, snap_day, snap_ms, snap_us};

    function automatic logic [31:0] exp_vec();
        return {DW'(m_t / DAYUS), MW'((m_t / UP) % MP), UW'(m_t % UP), m_ut, m_mt, m_dt, m_err,
                m_ovf, m_sv, DW'(m_sd), MW'(m_sm), UW'(m_su)};
    endfunction

    task automatic model_reset();
        m_t = 0; m_psc = 0; m_sd = 0; m_sm = 0; m_su = 0;
        m_ut = 0; m_mt = 0; m_dt = 0; m_err = 0; m_ovf = 0; m_sv = 0;
`ifdef SYS_TIME_BASE_ALARM_EN
        m_armed = 0; m_pend = 0; m_ad = 0; m_am = 0;
`endif
    endtask

    task automatic step();
        bit ok, wrap;
        @(posedge clk);
        if (!n_rst) model_reset();
        else begin
            ok = load && int'(load_us) < UP && int'(load_ms) < MP;
            wrap = 0;
            if (snap_req) begin
                m_sd = m_t / DAYUS; m_sm = (m_t / UP) % MP; m_su = m_t % UP; m_sv = 1;
            end else if (snap_ack) m_sv = 0;
            m_err = load && !ok;
            if (ok) begin
                m_t = int'(load_day) * DAYUS + int'(load_ms) * UP + int'(load_us);
                m_psc = 0; m_ut = 0; m_mt = 0; m_dt = 0;
            end else begin
                m_ut = m_psc == CT - 1;
                m_psc = m_ut ? 0 : m_psc + 1;
                if (m_ut) m_t = (m_t + 1) % FULL;
                m_mt = m_ut && m_t % UP == 0;
                m_dt = m_ut && m_t % DAYUS == 0;
                wrap = m_ut && m_t == 0;
            end
            m_ovf = wrap ? 1'b1 : clr_ovf ? 1'b0 : m_ovf;
`ifdef SYS_TIME_BASE_ALARM_EN
            begin
                bit fire;
                fire = m_armed && m_mt && (m_t / UP) % MP == m_am && m_t / DAYUS == m_ad;
                m_pend = fire ? 1'b1 : alarm_clr ? 1'b0 : m_pend;
                m_armed = alarm_arm ? 1'b1 : fire ? 1'b0 : m_armed;
                if (alarm_arm) begin m_ad = int'(alarm_day); m_am = int'(alarm_ms); end
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 0;
        repeat (2) @(negedge clk);
        model_reset();
        n_rst = 1;
    endtask

    task automatic test_reset();
        n_rst = 0;
        repeat (3) @(negedge clk);
        model_reset();
        total++;
        if (dut_vec !== 32'h0) $display("FAIL reset_hold got %h want 0", dut_vec);
        else passed++;
        n_rst = 1;
        #1;
        total++;
        if (dut_vec !== 32'h0) $display("FAIL reset_release got %h want 0", dut_vec);
        else passed++;
    endtask

    task automatic test_count();
        int nu = 0, nm = 0, nd = 0, first_day = -1, max_us = 0;
        for (int i = 1; i <= 900; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) $display("FAIL count c=%0d got %h want %h", i, dut_vec, exp_vec());
            else passed++;
            nu += int'(us_tick); nm += int'(ms_tick); nd += int'(day_tick);
            if (day_tick && first_day < 0) first_day = i;
            if (int'(us_of_ms) > max_us) max_us = int'(us_of_ms);
        end
        total++;
        if (nu != 225) $display("FAIL us_tick_count got %0d want 225", nu); else passed++;
        total++;
        if (nm != 22) $display("FAIL ms_tick_count got %0d want 22", nm); else passed++;
        total++;
        if (nd != 1 || first_day != 800)
            $display("FAIL day_tick_timing got n=%0d at %0d want n=1 at 800", nd, first_day);
        else passed++;
        total++;
        if (max_us != 9) $display("FAIL us_range got max %0d want 9", max_us); else passed++;
    endtask

    task automatic test_load_wrap();
        load = 1; load_day = 3; load_ms = 19; load_us = 9;
        step();
        load = 0;
        total++;
        if ({day, ms_of_day, us_of_ms, us_tick} !== {4'd3, 5'd19, 4'd9, 1'b0})
            $display("FAIL load_value got %0d/%0d/%0d t=%b want 3/19/9 t=0", day, ms_of_day, us_of_ms, us_tick);
        else passed++;
        repeat (4) step();
        total++;
        if ({day, ms_of_day, us_of_ms, ms_tick, day_tick} !== {4'd4, 5'd0, 4'd0, 2'b11})
            $display("FAIL load_wrap got %0d/%0d/%0d mt=%b dt=%b want 4/0/0 1 1", day, ms_of_day, us_of_ms, ms_tick, day_tick);
        else passed++;
        step();
        total++;
        if ({ms_tick, day_tick} !== 2'b00 || dut_vec !== exp_vec())
            $display("FAIL tick_width got %h want %h", dut_vec, exp_vec());
        else passed++;
    endtask

    task automatic test_load_invalid();
        load = 1; load_day = 7; load_ms = 20; load_us = 2;
        step();
        load = 0;
        total++;
        if (load_err !== 1'b1 || dut_vec !== exp_vec())
            $display("FAIL load_invalid got %h want %h", dut_vec, exp_vec());
        else passed++;
        step();
        total++;
        if (load_err !== 1'b0 || dut_vec !== exp_vec())
            $display("FAIL load_err_pulse got %h want %h", dut_vec, exp_vec());
        else passed++;
    endtask

    task automatic test_ovf();
        load = 1; load_day = 15; load_ms = 19; load_us = 9;
        step();
        load = 0;
        repeat (4) step();
        total++;
        if (day_ovf !== 1'b1 || day !== 4'd0) $display("FAIL ovf_set got ovf=%b day=%0d want 1 0", day_ovf, day);
        else passed++;
        clr_ovf = 1;
        step();
        clr_ovf = 0;
        total++;
        if (day_ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", day_ovf); else passed++;
        load = 1;
        step();
        load = 0;
        repeat (3) step();
        clr_ovf = 1;
        step();
        clr_ovf = 0;
        total++;
        if (day_ovf !== 1'b1 || dut_vec !== exp_vec())
            $display("FAIL ovf_set_wins got ovf=%b vec=%h want 1 %h", day_ovf, dut_vec, exp_vec());
        else passed++;
        clr_ovf = 1;
        step();
        clr_ovf = 0;
    endtask

    task automatic test_snapshot();
        load = 1; load_day = 1; load_ms = 2; load_us = 9;
        step();
        load = 0;
        repeat (3) step();
        snap_req = 1;
        step();
        snap_req = 0;
        total++;
        if ({snap_vld, snap_day, snap_ms, snap_us, ms_of_day, us_of_ms} !== {1'b1, 4'd1, 5'd2, 4'd9, 5'd3, 4'd0})
            $display("FAIL snap_pre_edge got v=%b %0d/%0d/%0d live %0d/%0d want 1 1/2/9 live 3/0",
                     snap_vld, snap_day, snap_ms, snap_us, ms_of_day, us_of_ms);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (snap_vld !== 1'b1) $display("FAIL snap_hold c=%0d got %b want 1", i, snap_vld); else passed++;
        end
        snap_ack = 1;
        step();
        snap_ack = 0;
        total++;
        if (snap_vld !== 1'b0) $display("FAIL snap_ack got %b want 0", snap_vld); else passed++;
        snap_req = 1;
        step();
        snap_req = 0;
        repeat (6) step();
        snap_req = 1;
        step();
        snap_req = 0;
        total++;
        if (snap_vld !== 1'b1 || dut_vec !== exp_vec())
            $display("FAIL snap_overwrite got %h want %h", dut_vec, exp_vec());
        else passed++;
        snap_req = 1; snap_ack = 1;
        step();
        snap_req = 0; snap_ack = 0;
        total++;
        if (snap_vld !== 1'b1 || dut_vec !== exp_vec())
            $display("FAIL snap_req_ack got %h want %h", dut_vec, exp_vec());
        else passed++;
        snap_ack = 1;
        step();
        snap_ack = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            load = $urandom_range(0, 49) == 0;
            load_day = DW'($urandom); load_ms = MW'($urandom); load_us = UW'($urandom);
            snap_req = $urandom_range(0, 7) == 0;
            snap_ack = $urandom_range(0, 3) == 0;
            clr_ovf = $urandom_range(0, 39) == 0;
`ifdef SYS_TIME_BASE_ALARM_EN
            alarm_arm = $urandom_range(0, 99) == 0;
            alarm_day = DW'($urandom_range(0, 1)); alarm_ms = MW'($urandom_range(0, 19));
            alarm_clr = $urandom_range(0, 99) == 0;
`endif
            step();
            total++;
            if (dut_vec !== exp_vec()) $display("FAIL random c=%0d got %h want %h", i, dut_vec, exp_vec());
            else passed++;
`ifdef SYS_TIME_BASE_ALARM_EN
            total++;
            if (alarm_pend !== m_pend) $display("FAIL random_alarm c=%0d got %b want %b", i, alarm_pend, m_pend);
            else passed++;
`endif
        end
        load = 0; snap_req = 0; snap_ack = 0; clr_ovf = 0;
`ifdef SYS_TIME_BASE_ALARM_EN
        alarm_arm = 0; alarm_clr = 0;
`endif
    endtask

    task automatic test_reset_mid();
        snap_req = 1;
        step();
        snap_req = 0;
        #2 n_rst = 0;
        #1;
        total++;
        if (dut_vec !== 32'h0) $display("FAIL reset_mid got %h want 0", dut_vec); else passed++;
        @(negedge clk);
        model_reset();
        n_rst = 1;
        step();
        total++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_resume got %h want %h", dut_vec, exp_vec());
        else passed++;
    endtask

`ifdef SYS_TIME_BASE_ALARM_EN
    task automatic test_alarm();
        int first = -1;
        n_rst = 0;
        repeat (2) @(negedge clk);
        model_reset();
        alarm_arm = 1; alarm_day = 0; alarm_ms = 5;
        n_rst = 1;
        for (int i = 1; i <= 260; i++) begin
            step();
            alarm_arm = 0;
            if (alarm_pend && first < 0) first = i;
        end
        total++;
        if (first != 200) $display("FAIL alarm_time got %0d want 200", first); else passed++;
        alarm_clr = 1;
        step();
        alarm_clr = 0;
        load = 1; load_day = 0; load_ms = 4; load_us = 0;
        step();
        load = 0;
        repeat (60) step();
        total++;
        if (alarm_pend !== 1'b0) $display("FAIL alarm_one_shot got %b want 0", alarm_pend); else passed++;
        alarm_arm = 1; alarm_ms = 5;
        step();
        alarm_arm = 0;
        load = 1; load_ms = 5;
        step();
        load = 0;
        step();
        total++;
        if (alarm_pend !== 1'b0) $display("FAIL alarm_load got %b want 0", alarm_pend); else passed++;
        alarm_arm = 1; alarm_ms = 6;
        step();
        alarm_arm = 0;
        repeat (45) step();
        total++;
        if (alarm_pend !== 1'b1 || alarm_pend !== m_pend)
            $display("FAIL alarm_rearm got %b want 1", alarm_pend);
        else passed++;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_count();
        test_load_wrap();
        test_load_invalid();
        test_ovf();
        test_snapshot();
        test_random();
        test_reset_mid();
`ifdef SYS_TIME_BASE_ALARM_EN
        test_alarm();
`endif
        do_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
